// File: rtl/fp_mul_arbiter_pkg.sv
// Shared constants and types for the floating-point unit arbiters.
package fp_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned MUL_STEPS = 24;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier-side signals of the shared multiplier arbiter.
interface fp_mul_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]              req_valid;
    logic [fp_pkg::FP_W*NREQ-1:0] req_x;
    logic [fp_pkg::FP_W*NREQ-1:0] req_y;
    logic [NREQ-1:0]              req_ready;
    logic [NREQ-1:0]              resp_valid;
    logic [fp_pkg::FP_W-1:0]      resp_z;
    logic                         resp_err;
    logic                         busy;
    logic                         mul_run;
    logic [fp_pkg::FP_W-1:0]      mul_x;
    logic [fp_pkg::FP_W-1:0]      mul_y;
    logic                         mul_stall;
    logic [fp_pkg::FP_W-1:0]      mul_z;

    // Arbiter side.
    modport slave (
        input  req_valid, req_x, req_y, mul_stall, mul_z,
        output req_ready, resp_valid, resp_z, resp_err, busy, mul_run, mul_x, mul_y
    );

    // Requesters plus multiplier side.
    modport master (
        output req_valid, req_x, req_y, mul_stall, mul_z,
        input  req_ready, resp_valid, resp_z, resp_err, busy, mul_run, mul_x, mul_y
    );
endinterface

// File: rtl/fp_mul_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    int unsigned     pos;
    logic [IdxW-1:0] sel;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            pos = (int'(ptr_i) + k) % NREQ;
            sel = IdxW'(pos);
            if (req_i[sel]) begin
                gnt_o      = '0;
                gnt_o[sel] = 1'b1;
                idx_o      = sel;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP multiplier between NREQ requesters,
// with a forced idle cycle between operations and a hung-operation timeout.
module fp_mul_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input logic             clk,
    input logic             rst,
    fp_mul_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [FP_W-1:0]   opx_q, opx_d;
    logic [FP_W-1:0]   opy_q, opy_d;
    logic [FP_W-1:0]   zreg_q, zreg_d;
    logic              err_q, err_d;
    logic              mul_run_q, mul_run_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // rr_ptr is advanced on entry to DONE, so DONE arbitrates with the new pointer.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        opx_d        = opx_q;
        opy_d        = opy_q;
        zreg_d       = '0;
        err_d        = 1'b0;
        mul_run_d    = 1'b0;
        resp_valid_d = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (pick_any) begin
                    state_d   = StRun;
                    owner_d   = pick_idx;
                    opx_d     = bus.req_x[FP_W*int'(pick_idx) +: FP_W];
                    opy_d     = bus.req_y[FP_W*int'(pick_idx) +: FP_W];
                    cnt_d     = '0;
                    mul_run_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (!bus.mul_stall || cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d               = StDone;
                    zreg_d                = bus.mul_stall ? '0 : bus.mul_z;
                    err_d                 = bus.mul_stall;
                    resp_valid_d[owner_q] = 1'b1;
                    rr_ptr_d = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end else begin
                    mul_run_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            opx_q        <= '0;
            opy_q        <= '0;
            zreg_q       <= '0;
            err_q        <= 1'b0;
            mul_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            opx_q        <= opx_d;
            opy_q        <= opy_d;
            zreg_q       <= zreg_d;
            err_q        <= err_d;
            mul_run_q    <= mul_run_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.req_ready  = (state_q == StRun) ? '0 : pick_gnt;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_z     = zreg_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = busy_q;
    assign bus.mul_run    = mul_run_q;
    assign bus.mul_x      = opx_q;
    assign bus.mul_y      = opy_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: transaction-level model checked every cycle plus
// hand-computed latency and product expectations.
module tb_fp_mul_arbiter;
    import fp_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 32;
    localparam int MIdle   = 0;
    localparam int MRun    = 1;
    localparam int MDone   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    logic hang = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    fp_mul_arbiter_if #(.NREQ(NREQ)) bus ();

    fp_mul_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Truncating single-precision multiply for normal operands; zero exponent gives +0.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int          e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
        m = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    // Multiplier stub: stall drops on the MUL_STEPS-th run cycle unless hung.
    int unsigned step = 0;
    always @(posedge clk) step <= bus.mul_run ? step + 1 : 0;
    assign bus.mul_stall = bus.mul_run && (hang || step != MUL_STEPS - 1);
    assign bus.mul_z     = fpmul(bus.mul_x, bus.mul_y);

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] r;
        r = 1;
        return r << i;
    endfunction

    // Transaction-level model.
    int          m_phase = MIdle;
    int          m_ptr = 0;
    int          m_owner = 0;
    int          m_runc = 0;
    int          m_pick;
    logic [31:0] m_ox = 0, m_oy = 0, m_z = 0;
    logic        m_err = 0;

    always_comb m_pick = pick(bus.req_valid, m_ptr);

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= MIdle;
            m_ptr   <= 0;
            m_owner <= 0;
            m_runc  <= 0;
            m_ox    <= 0;
            m_oy    <= 0;
            m_z     <= 0;
            m_err   <= 0;
        end else if (m_phase == MRun) begin
            m_runc <= m_runc + 1;
            if (!bus.mul_stall || m_runc + 1 == TIMEOUT) begin
                m_z     <= bus.mul_stall ? 32'h0 : fpmul(m_ox, m_oy);
                m_err   <= bus.mul_stall;
                m_phase <= MDone;
                m_ptr   <= (m_owner + 1) % NREQ;
            end
        end else if (m_pick >= 0) begin
            m_owner <= m_pick;
            m_ox    <= bus.req_x[32*m_pick +: 32];
            m_oy    <= bus.req_y[32*m_pick +: 32];
            m_runc  <= 0;
            m_phase <= MRun;
        end else begin
            m_phase <= MIdle;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready),
                (m_phase != MRun && m_pick >= 0) ? 32'(onehot(m_pick)) : 32'h0);
            chk("resp_valid", 32'(bus.resp_valid), (m_phase == MDone) ? 32'(onehot(m_owner)) : 0);
            chk("resp_z", bus.resp_z, (m_phase == MDone) ? m_z : 32'h0);
            chk("resp_err", 32'(bus.resp_err), (m_phase == MDone) ? 32'(m_err) : 0);
            chk("mul_run", 32'(bus.mul_run), 32'(m_phase == MRun));
            chk("busy", 32'(bus.busy), 32'(m_phase != MIdle));
            chk("mul_x", bus.mul_x, m_ox);
            chk("mul_y", bus.mul_y, m_oy);
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] x, input logic [31:0] y);
        bus.req_valid[i]    = v;
        bus.req_x[32*i +: 32] = x;
        bus.req_y[32*i +: 32] = y;
    endtask

    // Returns the cycle index of the response (first negedge is 1) and run-high cycles seen.
    task automatic wait_resp(input int bound, output int lat, output int runs);
        lat  = -1;
        runs = 0;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (bus.resp_valid != 0) begin
                lat = n;
                return;
            end
            if (bus.mul_run) runs++;
            @(posedge clk);
            #1;
        end
    endtask

    int lat, runs;

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        step_cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_mul_run", 32'(bus.mul_run), 0);
        chk("reset_resp_valid", 32'(bus.resp_valid), 0);
        step_cyc();
        rst = 1'b0;

        // Single request: 2.0 x 3.0.
        set_req(0, 1, 32'h40000000, 32'h40400000);
        step_cyc();
        set_req(0, 0, 32'h40000000, 32'h40400000);
        wait_resp(100, lat, runs);
        chk("t1_latency", lat, 25);
        chk("t1_run_cycles", runs, 24);
        chk("t1_resp_z", bus.resp_z, 32'h40C00000);
        chk("t1_resp_err", 32'(bus.resp_err), 0);
        chk("t1_resp_valid", 32'(bus.resp_valid), 1);
        step_cyc();

        // Simultaneous after reset: 1.5 x 1.5 then -2.0 x 0.5.
        rst = 1'b1;
        step_cyc();
        rst = 1'b0;
        set_req(0, 1, 32'h3FC00000, 32'h3FC00000);
        set_req(1, 1, 32'hC0000000, 32'h3F000000);
        step_cyc();
        set_req(0, 0, 32'h3FC00000, 32'h3FC00000);
        wait_resp(100, lat, runs);
        chk("t2a_latency", lat, 25);
        chk("t2a_resp_z", bus.resp_z, 32'h40100000);
        chk("t2a_resp_valid", 32'(bus.resp_valid), 1);
        chk("t2a_mul_run", 32'(bus.mul_run), 0);
        chk("t2a_req_ready", 32'(bus.req_ready), 2);
        step_cyc();
        set_req(1, 0, 32'hC0000000, 32'h3F000000);
        wait_resp(100, lat, runs);
        chk("t2b_latency", lat, 25);
        chk("t2b_resp_z", bus.resp_z, 32'hBF800000);
        chk("t2b_resp_valid", 32'(bus.resp_valid), 2);
        step_cyc();

        // Fairness with both requesters held valid.
        set_req(0, 1, 32'h40000000, 32'h40000000);
        set_req(1, 1, 32'h40400000, 32'h40000000);
        step_cyc();
        for (int op = 0; op < 6; op++) begin
            wait_resp(100, lat, runs);
            chk("t3_latency", lat, 25);
            chk("t3_owner", 32'(bus.resp_valid), (op % 2 == 0) ? 1 : 2);
            step_cyc();
        end
        set_req(0, 0, 32'h40000000, 32'h40000000);
        set_req(1, 0, 32'h40400000, 32'h40000000);
        wait_resp(100, lat, runs);
        step_cyc();

        // Timeout with a hung multiplier, then a normal operation.
        hang = 1'b1;
        set_req(0, 1, 32'h40000000, 32'h40400000);
        step_cyc();
        set_req(0, 0, 32'h40000000, 32'h40400000);
        wait_resp(100, lat, runs);
        chk("t4_latency", lat, TIMEOUT + 1);
        chk("t4_run_cycles", runs, TIMEOUT);
        chk("t4_resp_err", 32'(bus.resp_err), 1);
        chk("t4_resp_z", bus.resp_z, 32'h0);
        step_cyc();
        hang = 1'b0;
        set_req(0, 1, 32'h3FC00000, 32'h3FC00000);
        step_cyc();
        set_req(0, 0, 32'h3FC00000, 32'h3FC00000);
        wait_resp(100, lat, runs);
        chk("t4b_latency", lat, 25);
        chk("t4b_resp_z", bus.resp_z, 32'h40100000);
        chk("t4b_resp_err", 32'(bus.resp_err), 0);
        step_cyc();

        // Reset in RUN cycle 10: no response, pointer back to 0.
        set_req(0, 1, 32'h40000000, 32'h40400000);
        step_cyc();
        set_req(0, 0, 32'h40000000, 32'h40400000);
        repeat (9) step_cyc();
        rst = 1'b1;
        step_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_mul_run_after_rst", 32'(bus.mul_run), 0);
        step_cyc();
        wait_resp(30, lat, runs);
        chk("t5_no_resp", lat, -1);
        set_req(0, 1, 32'h40400000, 32'h40400000);
        set_req(1, 1, 32'h40000000, 32'h40000000);
        step_cyc();
        set_req(0, 0, 32'h40400000, 32'h40400000);
        wait_resp(100, lat, runs);
        chk("t5_owner", 32'(bus.resp_valid), 1);
        chk("t5_resp_z", bus.resp_z, 32'h41100000);
        step_cyc();
        set_req(1, 0, 32'h40000000, 32'h40000000);
        wait_resp(100, lat, runs);
        chk("t5b_resp_z", bus.resp_z, 32'h40800000);
        step_cyc();

        // Operand hold, late request, zero operand.
        set_req(0, 1, 32'h40000000, 32'h40400000);
        step_cyc();
        set_req(0, 0, 32'h12345678, 32'h9ABCDEF0);
        repeat (4) step_cyc();
        set_req(1, 1, 32'h40000000, 32'h40000000);
        @(negedge clk);
        chk("t6_mul_x_hold", bus.mul_x, 32'h40000000);
        chk("t6_mul_y_hold", bus.mul_y, 32'h40400000);
        chk("t6_late_ready", 32'(bus.req_ready), 0);
        step_cyc();
        wait_resp(100, lat, runs);
        chk("t6_resp_z", bus.resp_z, 32'h40C00000);
        chk("t6_late_grant", 32'(bus.req_ready), 2);
        step_cyc();
        set_req(1, 0, 32'h40000000, 32'h40000000);
        wait_resp(100, lat, runs);
        chk("t6b_resp_z", bus.resp_z, 32'h40800000);
        step_cyc();
        set_req(0, 1, 32'h00000001, 32'h40000000);
        step_cyc();
        set_req(0, 0, 32'h00000001, 32'h40000000);
        wait_resp(100, lat, runs);
        chk("t6c_zero_z", bus.resp_z, 32'h0);
        chk("t6c_zero_err", 32'(bus.resp_err), 0);
        repeat (3) step_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one floating-point multiplier between `NREQ` requesters (e.g. CPU FPU path and a vector/DMA engine) using round-robin arbitration. Owns the multiplier's `run` line, holds operands stable for the whole multi-cycle operation, captures the result on the cycle `stall` falls, and returns it to the winning requester. It also forces the mandatory idle cycle between operations and aborts a hung operation after a timeout.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, from 2 to 8.
- `TIMEOUT`, 32: maximum RUN cycles before abort; must exceed 24.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_x`, `req_y`  in  32*NREQ  operands; requester i uses bits [32i+31:32i].
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  NREQ  one-hot, single-cycle result strobe.
- `resp_z`  out  32  result; valid when any `resp_valid` bit is high.
- `resp_err`  out  1  high with `resp_valid` when the operation timed out; `resp_z` is then 0.
- `busy`  out  1  high in RUN and DONE.
- `mul_run`  out  1  multiplier `run` input.
- `mul_x`, `mul_y`  out  32  multiplier operands.
- `mul_stall`  in  1  multiplier `stall` output.
- `mul_z`  in  32  multiplier result.

## Operation
The block has three states: IDLE, RUN and DONE.

- **IDLE**:
  - `mul_run`=0.
  - If any `req_valid` bit is set, grant the first requester at or after `rr_ptr`, searching upward with wrap modulo NREQ.
  - Assert `req_ready[g]`; `req_ready` is combinational from `req_valid` and `rr_ptr`.
  - Latch `req_x[g]`/`req_y[g]` into `opx`/`opy`, store `g`, and go to RUN.
- **RUN**:
  - `mul_run`=1 and `mul_x`/`mul_y` = `opx`/`opy`, held constant the whole time.
  - A cycle counter increments each cycle.
  - When `mul_stall`=0, register `mul_z` into `zreg`, clear `err`, and go to DONE.
  - If the counter reaches TIMEOUT-1 with `mul_stall` still 1, set `zreg`=0, set `err`=1, and go to DONE.
- **DONE**:
  - `mul_run`=0. This cycle is required so the multiplier's step counter returns to 0.
  - Drive `resp_valid[g]`=1, `resp_z`=`zreg`, `resp_err`=`err`.
  - Set `rr_ptr` = (g+1) mod NREQ.
  - DONE performs the same grant and latch as IDLE (arbitration uses the updated pointer); on a grant go to RUN, otherwise go to IDLE.
- **Outputs outside these windows:**
  - `req_ready` is 0 in RUN.
  - `resp_*` are 0 outside DONE.
  - `mul_x`/`mul_y` hold their last values when not in RUN.
- **Width rule:** the counter is `$clog2(TIMEOUT)` bits wide and cleared on entry to RUN.
- **Requester side:** a requester that drops `req_valid` without being granted simply loses its turn. No state is kept per requester other than `rr_ptr`.

## Timing
- **Reset:** state=IDLE, `rr_ptr`=0, counter=0, `zreg`=0, `err`=0. All outputs are 0 (`req_ready` is 0 until a `req_valid` bit is high).
- **Reset mid-RUN:** `mul_run` is 0 in the cycle after the reset edge. The in-flight result is discarded and no `resp_valid` is issued.
- **Normal operation with a 24-step multiplier:**
  - Grant at cycle 0.
  - RUN during cycles 1–24; `mul_stall`=0 in cycle 24.
  - DONE / response in cycle 25; latency is 25 cycles.
  - Back-to-back: the next grant is in cycle 25 and its RUN starts in cycle 26, giving a throughput of one operation per 25 cycles.
- **Timeout:** RUN occupies exactly TIMEOUT cycles and the response is in cycle TIMEOUT+1.
- **Simultaneous requests:** the lowest index at or after `rr_ptr` wins. A continuously requesting port waits at most NREQ-1 operations.
- **Late request:** `req_valid` rising during RUN is not granted before DONE.

## Structure
- **Shared package `fp_pkg`:**
  - `MUL_STEPS` = 24.
  - The FP operand width 32.
  - Typedef for the state enum {IDLE, RUN, DONE}.
- **Sub-module `rr_pick`:** combinational round-robin selector taking `req_valid` and `rr_ptr`, producing a one-hot grant and a binary index. It is reusable by future adder/divider arbiters.
- **Multiplier:** instantiated outside this block and connected through the `mul_*` ports.

## Test plan
- **Single request:** req0 with x=0x40000000, y=0x40400000 (2.0×3.0) at cycle 0 → `resp_valid[0]` at cycle 25, `resp_z`=0x40C00000, `resp_err`=0, and `mul_run` high for exactly cycles 1–24.
- **Simultaneous requests after reset:** req0=1.5×1.5 and req1=−2.0×0.5 presented together → req0 served first with `resp_z`=0x40100000 at cycle 25; req1 granted in cycle 25 with `resp_z`=0xBF800000 at cycle 50; `mul_run`=0 in cycle 25.
- **Fairness:** req0 and req1 held permanently valid for 6 operations → grants alternate 0,1,0,1,0,1 with no starvation.
- **Timeout:** a stub multiplier holds `mul_stall`=1 forever, TIMEOUT=32 → `resp_valid` at cycle 33 with `resp_err`=1 and `resp_z`=0; the next request is served normally.
- **Reset mid-RUN:** `rst` pulsed at cycle 10 of RUN → `mul_run`=0 at cycle 11, no `resp_valid`, `rr_ptr`=0; a subsequent request completes with the correct product.
- **Operand hold and zero operand:** requester changes `req_x` during RUN → `mul_x` stays constant; an operand with x exponent 0 → `resp_z`=0x00000000.
